// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: streams a program image into instruction memory, pads the
// rest of the memory with NOPs, holds the processor in reset for a few
// cycles, then releases it and optionally halts it after a fixed cycle budget.
//
// Ports
//   clk, reset (async active-low)
//   start, prog_len     : load request and word count, sampled together
//   in_valid/in_data    : program word stream, in_ready backpressure
//   imem_we/addr/wdata  : instruction-memory write port
//   cpu_reset           : active-high processor reset
//   busy, done, err     : status (LOAD/FILL/HOLD, HALT, sticky bad length)
//   cycle_count         : processor cycles since last release
module imem_boot_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int RESET_HOLD = 2,
  parameter int RUN_LIMIT  = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       cycle_count
);

  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH-1);
  localparam logic [31:0]       HOLD_LAST = 32'(RESET_HOLD-1);
  localparam logic [31:0]       LIMIT     = 32'(RUN_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FILL, S_HOLD, S_RUN, S_HALT
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [31:0]       r_hold;
  logic [31:0]       r_cnt;
  logic              r_err;

  logic        w_len_ok, w_can_start, w_start_go, w_accept, w_load_last;
  logic        w_addr_last;
  logic [31:0] w_cnt_inc;

  // Only IDLE, RUN and HALT listen to start; a running program is aborted.
  assign w_len_ok    = (prog_len != '0) && (prog_len <= LEN_MAX);
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_HALT);
  assign w_start_go  = start && w_can_start && w_len_ok;
  assign w_accept    = (r_state == S_LOAD) && in_valid;
  assign w_load_last = w_accept && ({1'b0, r_addr} == (r_len - 1'b1));
  assign w_addr_last = (r_addr == ADDR_LAST);
  assign w_cnt_inc   = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_wdata = 32'h0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (w_start_go) w_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (w_accept) begin
          imem_we    = 1'b1;
          imem_wdata = in_data;
        end
        // A full-depth image has nothing left to pad.
        if (w_load_last) w_next = (r_len < LEN_MAX) ? S_FILL : S_HOLD;
      end
      S_FILL: begin
        imem_we = 1'b1;
        if (w_addr_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold == HOLD_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        // Abort takes priority over the automatic halt.
        if (start)                                 w_next = w_len_ok ? S_LOAD : S_IDLE;
        else if (RUN_LIMIT != 0 && w_cnt_inc == LIMIT) w_next = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_go) begin
        r_addr <= '0;
        r_len  <= prog_len;
        r_cnt  <= '0;
      end else begin
        // Address parks at the top word instead of wrapping back to 0.
        if ((w_accept || r_state == S_FILL) && !w_addr_last) r_addr <= r_addr + 1'b1;
        if (r_state == S_RUN) r_cnt <= w_cnt_inc;
      end
      if (start && w_can_start) r_err <= !w_len_ok;
      r_hold <= (r_state == S_HOLD) ? r_hold + 32'd1 : 32'd0;
    end
  end

  assign imem_addr   = r_addr;
  assign cpu_reset   = (r_state != S_RUN);
  assign busy        = (r_state == S_LOAD) || (r_state == S_FILL) || (r_state == S_HOLD);
  assign done        = (r_state == S_HALT);
  assign err         = r_err;
  assign cycle_count = r_cnt;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;
  localparam int AW  = 10;
  localparam int DEP = 1024;
  localparam int RH  = 2;
  localparam int RL  = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready, imem_we, cpu_reset, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, cycle_count;

  imem_boot_ctrl #(.ADDR_W(AW), .DEPTH(DEP), .RESET_HOLD(RH), .RUN_LIMIT(RL)) dut (
    .clk(clk), .reset(rst_n), .start(start), .prog_len(prog_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state: the image sent, and what the memory saw.
  logic [31:0]      img[$];
  logic [AW+31:0]   wq[$];
  int hold_n, run_n, run_bad, inv_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Observer: write log, HOLD-cycle count, RUN-cycle count and counter tracking.
  always @(negedge clk) begin
    if (imem_we) wq.push_back({imem_addr, imem_wdata});
    if (busy && !imem_we && !in_ready) hold_n++;
    if (!cpu_reset) begin
      if (cycle_count != 32'(run_n)) run_bad++;
      run_n++;
    end
    if (imem_we && !busy) inv_bad++;
    if (done && (busy || !cpu_reset)) inv_bad++;
    if (!cpu_reset && busy) inv_bad++;
  end

  task automatic feed(input int len, input int gap);
    int sent, nrdy;
    bit first;
    img.delete();
    for (int i = 0; i < len; i++) img.push_back($urandom);
    @(posedge clk); #1;
    start = 1'b1; prog_len = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    wq.delete(); hold_n = 0; run_n = 0; run_bad = 0; inv_bad = 0;
    sent = 0; nrdy = 0; first = 1'b1;
    while (sent < len) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = img[sent];
      if (!first) begin
        // stray starts while loading must be ignored
        start    = ($urandom_range(7) == 0);
        prog_len = (AW+1)'($urandom_range(2047));
      end
      @(negedge clk);
      if (first) begin
        chk("ready_latency", in_ready, 1);
        chk("cpu_reset_in_load", cpu_reset, 1);
        chk("count_cleared", cycle_count, 0);
        chk("addr_cleared", imem_addr, 0);
        chk("err_cleared", err, 0);
        first = 1'b0;
      end else if (!in_ready) nrdy++;
      @(posedge clk); #1;
      if (in_valid) sent++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("ready_through_load", nrdy, 0);
  endtask

  task automatic finish_chk(input int len);
    int cyc, bad, first_bad;
    cyc = 0; bad = 0; first_bad = -1;
    while (!done && cyc < 5000) begin @(negedge clk); #1; cyc++; end
    chk("done", done, 1);
    chk("n_writes", wq.size(), DEP);
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] !== {AW'(i), (i < len) ? img[i] : 32'h0}) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    chk($sformatf("bad_writes(first %0d)", first_bad), bad, 0);
    chk("hold_cycles", hold_n, RH);
    chk("run_cycles", run_n, RL);
    chk("run_count_track", run_bad, 0);
    chk("final_count", cycle_count, RL);
    chk("err_after_load", err, 0);
    chk("invariants", inv_bad, 0);
    repeat (3) @(negedge clk);
    chk("halt_count_hold", cycle_count, RL);
  endtask

  task automatic bad_start(input int len);
    logic [31:0] cnt0;
    cnt0 = cycle_count;
    @(posedge clk); #1;
    start = 1'b1; prog_len = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    wq.delete();
    repeat (3) @(negedge clk);
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_no_write", wq.size(), 0);
    chk("bad_cpu_reset", cpu_reset, 1);
    chk("bad_count_hold", cycle_count, cnt0);
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    bad_start(0);
    bad_start(1025);
    bad_start($urandom_range(2047, 1025));

    feed(2, 0);     finish_chk(2);
    feed(11, 0);    finish_chk(11);
    feed(4, 50);    finish_chk(4);
    feed(1024, 20); finish_chk(1024);
    bad_start(0);
    feed(1, 0);     finish_chk(1);

    // abort at RUN cycle 10
    feed(15, 30);
    cyc = 0;
    while (run_n < 10 && cyc < 5000) begin @(negedge clk); #1; cyc++; end
    chk("reach_run10", run_n, 10);
    feed(3, 0);     finish_chk(3);

    for (int k = 0; k < 3; k++) begin
      int len;
      len = $urandom_range(1024, 1);
      feed(len, $urandom_range(70));
      finish_chk(len);
    end

    // reset in the middle of the NOP fill
    feed(20, 0);
    cyc = 0;
    while (!(imem_we && imem_addr == AW'(500)) && cyc < 2000) begin @(negedge clk); #1; cyc++; end
    chk("fill_at_500", imem_addr, 500);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", imem_we, 0);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wq.delete();
    repeat (5) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_no_write", wq.size(), 0);
    chk("post_rst_ready", in_ready, 0);
    chk("post_rst_addr", imem_addr, 0);
    feed(7, 10);    finish_chk(7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
